// File: rtl/cc_psr_flags_pkg.sv
// cc_psr_flags_pkg: shared constants for the PSR icc register and the
// Bicc/Ticc condition resolver (condition codes, icc bit indices, FSM states).
package cc_psr_flags_pkg;

    // icc bit positions inside the 4-bit {N,Z,V,C} vector
    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

    // SPARC Bicc condition field encodings
    localparam logic [3:0] BN   = 4'b0000;
    localparam logic [3:0] BE   = 4'b0001;
    localparam logic [3:0] BLE  = 4'b0010;
    localparam logic [3:0] BL   = 4'b0011;
    localparam logic [3:0] BLEU = 4'b0100;
    localparam logic [3:0] BCS  = 4'b0101;
    localparam logic [3:0] BNEG = 4'b0110;
    localparam logic [3:0] BVS  = 4'b0111;
    localparam logic [3:0] BA   = 4'b1000;
    localparam logic [3:0] BNE  = 4'b1001;
    localparam logic [3:0] BG   = 4'b1010;
    localparam logic [3:0] BGE  = 4'b1011;
    localparam logic [3:0] BGU  = 4'b1100;
    localparam logic [3:0] BCC  = 4'b1101;
    localparam logic [3:0] BPOS = 4'b1110;
    localparam logic [3:0] BVC  = 4'b1111;

    // Resolver sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESOLVE = 2'd2
    } psr_state_t;

endpackage

// File: rtl/cc_psr_flags_if.sv
// cc_psr_flags_if: ALU flag, PSR read/write and condition-request signals
// between the control unit (master) and the PSR flag block (slave).
interface cc_psr_flags_if #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_COND = 4
);
    logic                      CC_PSR_overflow_InLow;
    logic                      CC_PSR_carry_InLow;
    logic                      CC_PSR_negative_InLow;
    logic                      CC_PSR_zero_InLow;
    logic                      CC_PSR_setFlags_In;
    logic                      CC_PSR_write_In;
    logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_InBUS;
    logic [DATAWIDTH_COND-1:0] CC_PSR_condition_InBUS;
    logic                      CC_PSR_evaluate_In;
    logic [DATAWIDTH_BUS-1:0]  CC_PSR_data_OutBUS;
    logic [3:0]                CC_PSR_icc_OutBUS;
    logic                      CC_PSR_taken_Out;
    logic                      CC_PSR_done_Out;
    logic                      CC_PSR_busy_Out;

    modport master (
        output CC_PSR_overflow_InLow, CC_PSR_carry_InLow, CC_PSR_negative_InLow,
               CC_PSR_zero_InLow, CC_PSR_setFlags_In, CC_PSR_write_In,
               CC_PSR_data_InBUS, CC_PSR_condition_InBUS, CC_PSR_evaluate_In,
        input  CC_PSR_data_OutBUS, CC_PSR_icc_OutBUS, CC_PSR_taken_Out,
               CC_PSR_done_Out, CC_PSR_busy_Out
    );

    modport slave (
        input  CC_PSR_overflow_InLow, CC_PSR_carry_InLow, CC_PSR_negative_InLow,
               CC_PSR_zero_InLow, CC_PSR_setFlags_In, CC_PSR_write_In,
               CC_PSR_data_InBUS, CC_PSR_condition_InBUS, CC_PSR_evaluate_In,
        output CC_PSR_data_OutBUS, CC_PSR_icc_OutBUS, CC_PSR_taken_Out,
               CC_PSR_done_Out, CC_PSR_busy_Out
    );
endinterface

// File: rtl/cc_condition_eval.sv
// cc_condition_eval: purely combinational SPARC condition evaluation of a
// 4-bit cond field against {N,Z,V,C}; shared by branch and trap logic.
module cc_condition_eval
    import cc_psr_flags_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic n;
    logic z;
    logic v;
    logic c;

    assign n = icc[ICC_N];
    assign z = icc[ICC_Z];
    assign v = icc[ICC_V];
    assign c = icc[ICC_C];

    // Upper eight codes are the complements of the lower eight
    always_comb begin
        taken = 1'b0;
        case (cond)
            BN:      taken = 1'b0;
            BE:      taken = z;
            BLE:     taken = z | (n ^ v);
            BL:      taken = n ^ v;
            BLEU:    taken = c | z;
            BCS:     taken = c;
            BNEG:    taken = n;
            BVS:     taken = v;
            BA:      taken = 1'b1;
            BNE:     taken = ~z;
            BG:      taken = ~(z | (n ^ v));
            BGE:     taken = ~(n ^ v);
            BGU:     taken = ~(c | z);
            BCC:     taken = ~c;
            BPOS:    taken = ~n;
            BVC:     taken = ~v;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_psr_flags.sv
// cc_psr_flags: architectural icc register with ALU capture and wrpsr load,
// PSR readback, and a request/done branch-condition resolver.
module cc_psr_flags
    import cc_psr_flags_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_COND = 4,
    parameter int ICC_LSB        = 20
) (
    input  logic          CC_PSR_CLOCK_50,
    input  logic          CC_PSR_RESET_InLow,
    cc_psr_flags_if.slave psr_bus
);

    logic [3:0]                icc_reg;
    logic [DATAWIDTH_COND-1:0] cond_reg;
    psr_state_t                state;
    psr_state_t                state_next;
    logic                      taken_reg;
    logic                      done_reg;
    logic                      eval_taken;
    logic                      icc_update;
    logic                      accept;
    logic [DATAWIDTH_BUS-1:0]  data_out;
    logic                      unused_data;

    // Only the icc field of the wrpsr word is stored; the rest is folded here
    assign unused_data = ^psr_bus.CC_PSR_data_InBUS;

    assign icc_update = psr_bus.CC_PSR_write_In | psr_bus.CC_PSR_setFlags_In;
    assign accept     = psr_bus.CC_PSR_evaluate_In && (state == ST_IDLE);

    // icc register: wrpsr beats ALU capture; ALU flags arrive active low
    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            icc_reg <= 4'b0000;
        end else if (psr_bus.CC_PSR_write_In) begin
            icc_reg <= psr_bus.CC_PSR_data_InBUS[ICC_LSB +: 4];
        end else if (psr_bus.CC_PSR_setFlags_In) begin
            icc_reg <= ~{psr_bus.CC_PSR_negative_InLow, psr_bus.CC_PSR_zero_InLow,
                         psr_bus.CC_PSR_overflow_InLow, psr_bus.CC_PSR_carry_InLow};
        end
    end

    // Resolver state register
    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a same-cycle flag update forces one settle cycle so the
    // resolution sees the new icc
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (psr_bus.CC_PSR_evaluate_In) begin
                    state_next = icc_update ? ST_SETTLE : ST_RESOLVE;
                end
            end
            ST_SETTLE:  state_next = ST_RESOLVE;
            ST_RESOLVE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Latch the condition field only when a request is accepted in IDLE
    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            cond_reg <= BN;
        end else if (accept) begin
            cond_reg <= psr_bus.CC_PSR_condition_InBUS;
        end
    end

    cc_condition_eval u_cond_eval (
        .cond  (cond_reg[3:0]),
        .icc   (icc_reg),
        .taken (eval_taken)
    );

    // Registered result: done pulses once per RESOLVE, taken holds until the next one
    always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
        if (!CC_PSR_RESET_InLow) begin
            taken_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= (state == ST_RESOLVE);
            if (state == ST_RESOLVE) begin
                taken_reg <= eval_taken;
            end
        end
    end

    // PSR readback word: icc in its field, everything else zero
    always_comb begin
        data_out = '0;
        data_out[ICC_LSB +: 4] = icc_reg;
    end

    assign psr_bus.CC_PSR_data_OutBUS = data_out;
    assign psr_bus.CC_PSR_icc_OutBUS  = icc_reg;
    assign psr_bus.CC_PSR_taken_Out   = taken_reg;
    assign psr_bus.CC_PSR_done_Out    = done_reg;
    assign psr_bus.CC_PSR_busy_Out    = (state != ST_IDLE);

endmodule
